// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: mode encoding and mode type.
package shift_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage : shift_pkg

// File: rtl/shift_cnt.sv
// Saturating shift counter: counts shifts since the last load/clear, pulses done
// on the edge where the count reaches WIDTH.
module shift_cnt #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic          zero,
    output logic [CW-1:0] cnt,
    output logic          done
);

    logic [CW-1:0] cnt_nxt;
    logic          done_nxt;
    logic          at_max;
    logic          at_last;

    assign at_max  = (cnt == CW'(WIDTH));
    assign at_last = (cnt == CW'(WIDTH - 1));

    // Next count and done pulse; saturation suppresses repeated done.
    always_comb begin
        cnt_nxt  = cnt;
        done_nxt = 1'b0;
        if (zero) begin
            cnt_nxt = '0;
        end else if (inc && !at_max) begin
            cnt_nxt  = cnt + CW'(1);
            done_nxt = at_last;
        end
    end

    // Count register with synchronous active-low reset and synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            done <= done_nxt;
        end
    end

endmodule : shift_cnt

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with shift counter and word-complete pulse.
// Optional feature: define SHIFT_REG_UNIV_ROTATE_EN to add the rot input,
// which turns shifts into rotates.
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    localparam int unsigned      CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  mode_t            mode,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    logic [WIDTH-1:0] q_nxt;
    logic             ins_r;
    logic             ins_l;
    logic             do_shift;
    logic             do_load;

    // Bits entering on a shift: serial inputs, or wrapped-around bits when rotating.
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    assign ins_r = rot ? q[0]       : sin_r;
    assign ins_l = rot ? q[WIDTH-1] : sin_l;
`else
    assign ins_r = sin_r;
    assign ins_l = sin_l;
`endif

    assign do_shift = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
    assign do_load  = en && (mode == MODE_LOAD);

    // Mode mux for the data register.
    always_comb begin
        q_nxt = q;
        if (en) begin
            case (mode)
                MODE_SHR:  q_nxt = {ins_r, q[WIDTH-1:1]};
                MODE_SHL:  q_nxt = {q[WIDTH-2:0], ins_l};
                MODE_LOAD: q_nxt = d;
                default:   q_nxt = q;
            endcase
        end
    end

    // Data register: reset beats clear beats mode operation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    shift_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (do_shift),
        .zero (do_load),
        .cnt  (cnt),
        .done (done)
    );

endmodule : shift_reg_univ

// File: tb/tb_shift_reg_univ.sv
// Directed self-checking bench for shift_reg_univ (WIDTH=8, RESET_VAL=8'hA5).
module tb_shift_reg_univ;
    import shift_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             clr;
    logic             en;
    mode_t            mode;
    logic             sin_r;
    logic             sin_l;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic [CW-1:0]    cnt;
    logic             done;

    int checks;
    int errors;

    shift_reg_univ #(
        .WIDTH     (WIDTH),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (en),
        .mode   (mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        .rot    (rot),
`endif
        .d      (d),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .cnt    (cnt),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        en   = 1'b1;
        mode = MODE_LOAD;
        d    = v;
        step();
    endtask

    logic exp_sr [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0; clr = 1'b0; en = 1'b0; mode = MODE_HOLD;
        sin_r = 1'b0; sin_l = 1'b0; d = '0;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        rot = 1'b0;
`endif

        // Reset
        step();
        chk("rst_q", 32'(q), 32'hA5);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sout_r", 32'(sout_r), 32'd1);
        chk("rst_sout_l", 32'(sout_l), 32'd1);

        // Reset glitch between edges has no effect
        rst = 1'b1;
        en  = 1'b1; mode = MODE_LOAD; d = 8'h11;
        step();
        chk("pre_glitch_q", 32'(q), 32'h11);
        en = 1'b0;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        step();
        chk("glitch_q", 32'(q), 32'h11);

        // Load then 8 right shifts
        load(8'hB4);
        chk("ld_q", 32'(q), 32'hB4);
        chk("ld_cnt", 32'(cnt), 32'd0);
        mode = MODE_SHR; sin_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("shr_sout_r%0d", i), 32'(sout_r), 32'(exp_sr[i]));
            step();
            if (i < 7) chk($sformatf("shr_done%0d", i), 32'(done), 32'd0);
        end
        chk("shr8_q", 32'(q), 32'h00);
        chk("shr8_cnt", 32'(cnt), 32'd8);
        chk("shr8_done", 32'(done), 32'd1);
        step();
        chk("shr9_done", 32'(done), 32'd0);
        chk("shr9_cnt", 32'(cnt), 32'd8);

        // Shift left with sin_l=1
        load(8'h01);
        mode = MODE_SHL; sin_l = 1'b1;
        step(); step(); step();
        chk("shl_q", 32'(q), 32'h0F);
        chk("shl_cnt", 32'(cnt), 32'd3);
        chk("shl_sout_l", 32'(sout_l), 32'd0);

        // Enable low holds
        load(8'h3C);
        en = 1'b0; mode = MODE_SHR; sin_r = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("en0_q", 32'(q), 32'h3C);
        chk("en0_cnt", 32'(cnt), 32'd0);
        chk("en0_done", 32'(done), 32'd0);
        en = 1'b1; mode = MODE_HOLD;
        step();
        chk("hold_q", 32'(q), 32'h3C);
        chk("hold_cnt", 32'(cnt), 32'd0);

        // Reset mid-word discards count; no done for the interrupted word
        load(8'hFF);
        mode = MODE_SHL; sin_l = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("mid_cnt7", 32'(cnt), 32'd7);
        rst = 1'b0;
        step();
        chk("mid_rst_q", 32'(q), 32'hA5);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        step();
        chk("post_rst_cnt", 32'(cnt), 32'd1);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_q", 32'(q), 32'h4A);

        // Clear beats load
        clr = 1'b1; en = 1'b1; mode = MODE_LOAD; d = 8'hFF;
        step();
        chk("clr_q", 32'(q), 32'h00);
        chk("clr_cnt", 32'(cnt), 32'd0);
        // Clear with enable low still clears
        clr = 1'b0;
        step();
        chk("ld_ff_q", 32'(q), 32'hFF);
        clr = 1'b1; en = 1'b0;
        step();
        chk("clr_en0_q", 32'(q), 32'h00);
        // Reset beats clear
        rst = 1'b0; clr = 1'b1;
        step();
        chk("rst_clr_q", 32'(q), 32'hA5);
        rst = 1'b1; clr = 1'b0;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
        // Rotate
        load(8'h81);
        rot = 1'b1; mode = MODE_SHR; sin_r = 1'b0;
        step();
        chk("rotr_q", 32'(q), 32'hC0);
        chk("rotr_cnt", 32'(cnt), 32'd1);
        rot = 1'b0;
        load(8'h81);
        rot = 1'b1; mode = MODE_SHL; sin_l = 1'b0;
        step();
        chk("rotl_q", 32'(q), 32'h03);
        rot = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_reg_univ

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register with synchronous active-low reset, synchronous clear, clock enable and four operating modes: hold, shift right, shift left and parallel load. It generalises the single-bit clearable D flip-flop to a WIDTH-bit register bank. It also tracks the number of shifts since the last load and pulses `done` when a full word has been shifted. It sits between parallel datapaths and serial links in lab designs as a serializer, deserializer or delay element.

## Interface
- `WIDTH`, default 8: register width in bits; legal range 2..32.
- `RESET_VAL`, default 0: value loaded into `q` on reset.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous active-low reset.
- `clr`  input  1  synchronous clear, active-high.
- `en`  input  1  clock enable for mode operations.
- `mode`  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `sin_r`  input  1  serial input entering the MSB on a right shift.
- `sin_l`  input  1  serial input entering the LSB on a left shift.
- `d`  input  WIDTH  parallel load data.
- `q`  output  WIDTH  register contents.
- `sout_r`  output  1  equals `q[0]`, the bit leaving on a right shift.
- `sout_l`  output  1  equals `q[WIDTH-1]`, the bit leaving on a left shift.
- `cnt`  output  $clog2(WIDTH+1)  shifts performed since the last load or clear; saturates at WIDTH.
- `done`  output  1  one-cycle pulse on the edge where `cnt` becomes WIDTH.

## Operation
- Priority at each rising edge is `rst`==0, then `clr`, then `en`/`mode`.
- Reset (`rst`==0):
  - `q`=RESET_VAL, `cnt`=0, `done`=0.
  - `d`, `mode`, `en` and `clr` are ignored.
- Clear (`clr`==1, `rst`==1):
  - `q`=0, `cnt`=0, `done`=0.
  - Takes effect regardless of `en`.
- When `en`==0, `q` and `cnt` hold and `done`=0.
- When `en`==1:
  - Hold: `q` and `cnt` unchanged.
  - Shift right: `q` <= {`sin_r`, `q[WIDTH-1:1]`}; `cnt`++ (saturating).
  - Shift left: `q` <= {`q[WIDTH-2:0]`, `sin_l`}; `cnt`++ (saturating).
  - Load: `q` <= `d`; `cnt`=0.
- `done` is 1 only in the cycle after the edge where `cnt` went from WIDTH-1 to WIDTH. Further shifts while `cnt` is saturated produce no new `done`.
- Left and right shifts both increment the same counter; no direction tracking.
- `sout_r` and `sout_l` are combinational taps of `q`; no extra latency.

## Timing
- All updates take effect one clock after the inputs are sampled; `q` and `cnt` have single-cycle latency.
- `rst` and `clr` are sampled only at rising edges. A pulse that does not span an edge has no effect.
- Deasserting `rst` makes the next edge a normal operation edge.
- Reset mid-shift discards the partial count; `done` never fires for an interrupted word.
- A load on the same edge as the WIDTH-th shift cannot occur, since `mode` is exclusive.
- Holding `clr` high with `en`=1 keeps `q`=0 regardless of `mode`.
- With WIDTH=8, a load followed by 8 consecutive enabled shifts produces `done` high in exactly the cycle after the 8th shift edge.

## Configuration
- Macro: `SHIFT_REG_UNIV_ROTATE_EN`.
- Defined:
  - Adds input `rot` (1 bit).
  - When `rot`==1, shifts rotate: right shift inserts `q[0]` at the MSB, left shift inserts `q[WIDTH-1]` at the LSB.
  - `sin_r`/`sin_l` are ignored in that case; `cnt` and `done` behave identically.
- Not defined:
  - No `rot` port.
  - Shifts always take serial inputs.

## Structure
- Shared package `shift_pkg`:
  - Mode encodings `MODE_HOLD`=2'b00, `MODE_SHR`=2'b01, `MODE_SHL`=2'b10, `MODE_LOAD`=2'b11.
  - A 2-bit mode typedef.
- Sub-module `shift_cnt`:
  - Saturating counter with synchronous active-low reset, clear, increment and zero inputs.
  - Generates `cnt` and the `done` pulse.
- The top level holds the data register and the mode mux.

## Test plan
- Reset: `rst`=0 over one edge with WIDTH=8, RESET_VAL=8'hA5 -> `q`=8'hA5, `cnt`=0, `done`=0. An `rst` glitch between edges leaves `q` unchanged.
- Load then shift right:
  - Stimulus: load 8'hB4, then 8 right shifts with `sin_r`=0.
  - `sout_r` sequence is 0,0,1,0,1,1,0,1.
  - After the 8th shift, `q`=0, `cnt`=8, `done`=1 for one cycle; a 9th shift gives `done`=0, `cnt`=8.
- Shift left: load 8'h01, 3 left shifts with `sin_l`=1 -> `q`=8'h0F, `cnt`=3.
- Enable and hold:
  - Load 8'h3C, then `en`=0 with `mode`=SHR for 4 cycles -> `q`=8'h3C, `cnt`=0.
  - `mode`=HOLD with `en`=1 -> unchanged.
- Priority:
  - `clr`=1 and `en`=1 with `mode`=LOAD and `d`=8'hFF -> `q`=0.
  - `rst`=0 and `clr`=1 simultaneously -> `q`=RESET_VAL.
- Rotate (macro defined): load 8'h81, `rot`=1, one right shift -> `q`=8'hC0; one left shift from 8'h81 -> `q`=8'h03.
